multi_mode_ff_bank: RTL and testbench



---
 rtl/ff_pkg.sv | 14 +
 rtl/ff_next_cell.sv | 53 +++++
 rtl/multi_mode_ff_bank.sv | 85 ++++++++
 tb/tb_multi_mode_ff_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared mode and S=R=1 policy encodings for the multi-mode flip-flop bank.
package ff_pkg;

    localparam logic [1:0] MODE_SR = 2'd0;
    localparam logic [1:0] MODE_JK = 2'd1;
    localparam logic [1:0] MODE_D  = 2'd2;
    localparam logic [1:0] MODE_T  = 2'd3;

    localparam int unsigned POL_HOLD = 0;
    localparam int unsigned POL_SET  = 1;
    localparam int unsigned POL_RST  = 2;
    localparam int unsigned POL_TOG  = 3;

endpackage

// File: rtl/ff_next_cell.sv
// Combinational single-bit next-state function for SR/JK/D/T modes.
module ff_next_cell
    import ff_pkg::*;
#(
    parameter int unsigned CONFLICT_POLICY = POL_HOLD
) (
    input  logic       q,
    input  logic       s,
    input  logic       r,
    input  logic [1:0] mode,
    output logic       q_nxt
);

    logic sr_conflict_nxt;

    // SR-mode resolution of s=r=1, fixed at elaboration
    always_comb begin
        sr_conflict_nxt = q;
        if (CONFLICT_POLICY == POL_SET) begin
            sr_conflict_nxt = 1'b1;
        end else if (CONFLICT_POLICY == POL_RST) begin
            sr_conflict_nxt = 1'b0;
        end else if (CONFLICT_POLICY == POL_TOG) begin
            sr_conflict_nxt = ~q;
        end
    end

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_SR: begin
                case ({s, r})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = sr_conflict_nxt;
                    default: q_nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({s, r})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            MODE_D:  q_nxt = s;
            MODE_T:  q_nxt = q ^ s;
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit flip-flop bank with runtime mode select, sync clear, clock enable
// and SR conflict monitoring (pulse, sticky flag, saturating event counter).
module multi_mode_ff_bank
    import ff_pkg::*;
#(
    parameter int unsigned       WIDTH           = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL       = '0,
    parameter int unsigned       CONFLICT_POLICY = POL_HOLD,
    parameter int unsigned       CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_nxt;
    logic             conflict_ev_c;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sticky_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_next_cell #(
            .CONFLICT_POLICY(CONFLICT_POLICY)
        ) u_cell (
            .q    (q[i]),
            .s    (s[i]),
            .r    (r[i]),
            .mode (mode),
            .q_nxt(q_nxt[i])
        );
    end

    // One event per edge regardless of how many bits collide
    assign conflict_ev_c = en && !sclr && (mode == MODE_SR) && (|(s & r));

    // A same-edge event outranks conflict_clr so it is never lost
    always_comb begin
        cnt_nxt    = conflict_cnt;
        sticky_nxt = conflict_sticky;
        if (conflict_ev_c) begin
            sticky_nxt = 1'b1;
            if (conflict_clr) begin
                cnt_nxt = CNT_W'(1);
            end else if (conflict_cnt != CNT_MAX) begin
                cnt_nxt = conflict_cnt + CNT_W'(1);
            end
        end else if (conflict_clr) begin
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q               <= RESET_VAL;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            if (sclr) begin
                q <= RESET_VAL;
            end else if (en) begin
                q <= q_nxt;
            end
            conflict        <= conflict_ev_c;
            conflict_sticky <= sticky_nxt;
            conflict_cnt    <= cnt_nxt;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench: four policy variants plus a narrow-counter variant share one stimulus.
module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       sclr;
    logic [1:0] mode;
    logic [3:0] s;
    logic [3:0] r;
    logic       conflict_clr;

    logic [3:0] q0, q1, q2, q3, q4;
    logic [3:0] qb0, qb1, qb2, qb3, qb4;
    logic       c0, c1, c2, c3, c4;
    logic       st0, st1, st2, st3, st4;
    logic [3:0] n0, n1, n2, n3;
    logic [1:0] n4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.CONFLICT_POLICY(0)) d0 (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .s(s), .r(r),
        .conflict_clr(conflict_clr), .q(q0), .qb(qb0), .conflict(c0),
        .conflict_sticky(st0), .conflict_cnt(n0));
    multi_mode_ff_bank #(.CONFLICT_POLICY(1)) d1 (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .s(s), .r(r),
        .conflict_clr(conflict_clr), .q(q1), .qb(qb1), .conflict(c1),
        .conflict_sticky(st1), .conflict_cnt(n1));
    multi_mode_ff_bank #(.CONFLICT_POLICY(2)) d2 (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .s(s), .r(r),
        .conflict_clr(conflict_clr), .q(q2), .qb(qb2), .conflict(c2),
        .conflict_sticky(st2), .conflict_cnt(n2));
    multi_mode_ff_bank #(.CONFLICT_POLICY(3)) d3 (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .s(s), .r(r),
        .conflict_clr(conflict_clr), .q(q3), .qb(qb3), .conflict(c3),
        .conflict_sticky(st3), .conflict_cnt(n3));
    multi_mode_ff_bank #(.CONFLICT_POLICY(0), .CNT_W(2)) d4 (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .s(s), .r(r),
        .conflict_clr(conflict_clr), .q(q4), .qb(qb4), .conflict(c4),
        .conflict_sticky(st4), .conflict_cnt(n4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sclr = 1'b0; mode = 2'd0;
        s = 4'b0000; r = 4'b0000; conflict_clr = 1'b0;

        // reset state
        #3;
        chk("rst_q0", 32'(q0), 32'h0);
        chk("rst_qb0", 32'(qb0), 32'hF);
        chk("rst_qb4", 32'(qb4), 32'hF);
        chk("rst_conf0", 32'(c0), 32'h0);
        chk("rst_sticky0", 32'(st0), 32'h0);
        chk("rst_cnt0", 32'(n0), 32'h0);
        step();
        chk("rst_hold_q0", 32'(q0), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // basic SR set then clear
        en = 1'b1; mode = 2'd0; s = 4'b0101; r = 4'b0000;
        step();
        chk("sr_set_q0", 32'(q0), 32'h5);
        chk("sr_set_conf0", 32'(c0), 32'h0);
        s = 4'b0000; r = 4'b0001;
        step();
        chk("sr_clr_q0", 32'(q0), 32'h4);
        chk("sr_clr_qb0", 32'(qb0), 32'hB);
        chk("sr_clr_conf0", 32'(c0), 32'h0);

        // load 0001 then SR s=r=0011 under each policy
        mode = 2'd2; s = 4'b0001; r = 4'b0000;
        step();
        chk("load_q0", 32'(q0), 32'h1);
        mode = 2'd0; s = 4'b0011; r = 4'b0011;
        step();
        chk("pol_hold_q", 32'(q0), 32'h1);
        chk("pol_set_q", 32'(q1), 32'h3);
        chk("pol_rst_q", 32'(q2), 32'h0);
        chk("pol_tog_q", 32'(q3), 32'h2);
        chk("pol_conf0", 32'(c0), 32'h1);
        chk("pol_conf3", 32'(c3), 32'h1);
        chk("pol_cnt1", 32'(n1), 32'h1);
        chk("pol_cnt2", 32'(n2), 32'h1);
        chk("pol_sticky3", 32'(st3), 32'h1);
        s = 4'b0000; r = 4'b0000;
        step();
        chk("pulse_end_conf0", 32'(c0), 32'h0);
        chk("pulse_end_conf2", 32'(c2), 32'h0);
        chk("pulse_cnt0", 32'(n0), 32'h1);
        chk("pulse_sticky0", 32'(st0), 32'h1);
        chk("pulse_sticky1", 32'(st1), 32'h1);
        chk("pulse_sticky2", 32'(st2), 32'h1);
        chk("pulse_cnt3", 32'(n3), 32'h1);

        // clear q to 0000 and the conflict state together
        mode = 2'd2; s = 4'b0000; conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        chk("clr_q0", 32'(q0), 32'h0);
        chk("clr_cnt0", 32'(n0), 32'h0);
        chk("clr_sticky0", 32'(st0), 32'h0);

        // JK toggle twice, T, D
        mode = 2'd1; s = 4'b1111; r = 4'b1111;
        step();
        chk("jk1_q0", 32'(q0), 32'hF);
        chk("jk1_conf0", 32'(c0), 32'h0);
        step();
        chk("jk2_q0", 32'(q0), 32'h0);
        chk("jk2_cnt0", 32'(n0), 32'h0);
        mode = 2'd3; s = 4'b1010; r = 4'b0000;
        step();
        chk("t_q0", 32'(q0), 32'hA);
        mode = 2'd2; s = 4'b0110; r = 4'b1111;
        step();
        chk("d_q0", 32'(q0), 32'h6);
        chk("d_conf0", 32'(c0), 32'h0);

        // saturating counter with CNT_W=2
        mode = 2'd0; s = 4'b1111; r = 4'b1111;
        step(); chk("sat1_cnt4", 32'(n4), 32'h1);
        step(); chk("sat2_cnt4", 32'(n4), 32'h2);
        step(); chk("sat3_cnt4", 32'(n4), 32'h3);
        step(); chk("sat4_cnt4", 32'(n4), 32'h3);
        step(); chk("sat5_cnt4", 32'(n4), 32'h3);
        chk("sat_cnt0", 32'(n0), 32'h5);
        chk("sat_sticky4", 32'(st4), 32'h1);
        chk("sat_hold_q0", 32'(q0), 32'h6);
        chk("sat_conf4", 32'(c4), 32'h1);
        s = 4'b0000; r = 4'b0000; conflict_clr = 1'b1;
        step();
        chk("cclr_cnt4", 32'(n4), 32'h0);
        chk("cclr_sticky4", 32'(st4), 32'h0);
        chk("cclr_conf4", 32'(c4), 32'h0);
        s = 4'b1111; r = 4'b1111;
        step();
        conflict_clr = 1'b0;
        chk("cclr_ev_cnt4", 32'(n4), 32'h1);
        chk("cclr_ev_sticky4", 32'(st4), 32'h1);
        chk("cclr_ev_conf4", 32'(c4), 32'h1);
        chk("cclr_ev_cnt0", 32'(n0), 32'h1);

        // enable low holds; sclr beats en and suppresses conflicts
        mode = 2'd2; s = 4'b1111; r = 4'b0000;
        step();
        chk("load_f_q0", 32'(q0), 32'hF);
        en = 1'b0; mode = 2'd0; s = 4'b1111; r = 4'b1111;
        step();
        chk("en0_q0", 32'(q0), 32'hF);
        chk("en0_conf0", 32'(c0), 32'h0);
        chk("en0_cnt0", 32'(n0), 32'h1);
        en = 1'b1; sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("sclr_q0", 32'(q0), 32'h0);
        chk("sclr_conf0", 32'(c0), 32'h0);
        chk("sclr_cnt0", 32'(n0), 32'h1);

        // mid-cycle async reset with a pending conflict pulse
        mode = 2'd2; s = 4'b1010; r = 4'b0000;
        step();
        mode = 2'd0; s = 4'b1000; r = 4'b1000;
        step();
        chk("pre_rst_q0", 32'(q0), 32'hA);
        chk("pre_rst_cnt0", 32'(n0), 32'h2);
        chk("pre_rst_conf0", 32'(c0), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_q0", 32'(q0), 32'h0);
        chk("arst_qb0", 32'(qb0), 32'hF);
        chk("arst_cnt0", 32'(n0), 32'h0);
        chk("arst_sticky0", 32'(st0), 32'h0);
        chk("arst_conf0", 32'(c0), 32'h0);
        mode = 2'd2; s = 4'b1111; r = 4'b0000;
        step();
        chk("arst_held_q0", 32'(q0), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_q0", 32'(q0), 32'h0);
        step();
        chk("first_edge_q0", 32'(q0), 32'hF);
        chk("first_edge_qb0", 32'(qb0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
